// File: rtl/nl_vc_in_buffer_pkg.sv
// Shared router types and helpers for the VC input buffer and its upstream credit stage.
package nl_vc_in_buffer_pkg;

  localparam int unsigned num_vcs   = 2;
  localparam int unsigned data_bits = 16;

  // Ceiling log2, never less than 1 so every derived vector has a real width.
  function automatic int unsigned clogb2(input int unsigned val);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < val) res++;
    if (res == 0) res = 1;
    return res;
  endfunction

  localparam int unsigned vc_index_bits = clogb2(num_vcs);

  typedef logic [num_vcs-1:0]       vc_t;
  typedef logic [vc_index_bits-1:0] vc_index_t;

  typedef struct packed {
    vc_t vc_id;
  } flit_ctrl_t;

  typedef struct packed {
    flit_ctrl_t           control;
    logic [data_bits-1:0] data;
  } flit_t;

  typedef struct packed {
    logic      credit_valid;
    vc_index_t credit;
  } chan_cntrl_t;

  function automatic vc_index_t oh2bin(input vc_t oh);
    vc_index_t res;
    res = '0;
    for (int i = 0; i < int'(num_vcs); i++) begin
      if (oh[i]) res |= vc_index_t'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/nl_vc_in_buffer_if.sv
// Link-side flit/dequeue/credit bundle between the router and the VC input buffer.
interface nl_vc_in_buffer_if;
  import nl_vc_in_buffer_pkg::*;

  flit_t                    flit;
  logic                     flit_valid;
  vc_t                      deq;
  flit_t [num_vcs-1:0]      vc_head;
  vc_t                      vc_head_valid;
  chan_cntrl_t              channel_cntrl_out;

  modport master (
    output flit, flit_valid, deq,
    input  vc_head, vc_head_valid, channel_cntrl_out
  );

  modport slave (
    input  flit, flit_valid, deq,
    output vc_head, vc_head_valid, channel_cntrl_out
  );

endinterface

// File: rtl/nl_vc_fifo.sv
// Single-VC flit FIFO; push and pop arrive already qualified against full/empty.
module nl_vc_fifo
  import nl_vc_in_buffer_pkg::*;
#(
  parameter int unsigned buf_depth = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  flit_t din,
  output flit_t head,
  output logic  full,
  output logic  empty
);

  localparam int unsigned ptr_bits = clogb2(buf_depth);
  localparam int unsigned cnt_bits = clogb2(buf_depth + 1);

  typedef logic [ptr_bits-1:0] ptr_t;
  typedef logic [cnt_bits-1:0] cnt_t;

  localparam ptr_t LastPtr = ptr_t'(buf_depth - 1);
  localparam cnt_t FullCnt = cnt_t'(buf_depth);

  flit_t mem [buf_depth];
  ptr_t  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t  occ_q, occ_d;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == FullCnt);
  assign head  = mem[rd_ptr_q];

  // Explicit wrap so non-power-of-two depths work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + ptr_t'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + ptr_t'(1);
    if (push && !pop)      occ_d = occ_q + cnt_t'(1);
    else if (pop && !push) occ_d = occ_q - cnt_t'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/nl_vc_in_buffer.sv
// Input-port VC buffer: per-VC FIFOs, head presentation and one-credit-per-dequeue return.
// Optional protocol checking and the buf_err port are enabled by NL_VC_BUF_CHECK_EN.
module nl_vc_in_buffer
  import nl_vc_in_buffer_pkg::*;
#(
  parameter int unsigned buf_depth = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  nl_vc_in_buffer_if.slave       bus
`ifdef NL_VC_BUF_CHECK_EN
  ,
  output logic                   buf_err
`endif
);

  vc_index_t   wr_vc;
  vc_t         wr_sel, push, pop, full, empty;
  flit_t       heads [num_vcs];
  chan_cntrl_t credit_d, credit_q;

  assign wr_vc = oh2bin(bus.flit.control.vc_id);
  // A write to a full VC is only accepted when that VC frees a slot in the same cycle.
  assign pop   = bus.deq & ~empty;
  assign push  = wr_sel & (~full | pop);

  for (genvar v = 0; v < int'(num_vcs); v++) begin : g_vc
    assign wr_sel[v] = bus.flit_valid && (wr_vc == vc_index_t'(v));

    nl_vc_fifo #(
      .buf_depth(buf_depth)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[v]),
      .pop  (pop[v]),
      .din  (bus.flit),
      .head (heads[v]),
      .full (full[v]),
      .empty(empty[v])
    );
  end

  always_comb begin
    for (int v = 0; v < int'(num_vcs); v++) bus.vc_head[v] = heads[v];
  end

  assign bus.vc_head_valid = ~empty;

  always_comb begin
    credit_d.credit_valid = |pop;
    credit_d.credit       = oh2bin(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) credit_q <= '0;
    else     credit_q <= credit_d;
  end

  assign bus.channel_cntrl_out = credit_q;

`ifdef NL_VC_BUF_CHECK_EN
  logic err_evt, err_d, err_q;

  always_comb begin
    err_evt = 1'b0;
    if (|(wr_sel & full & ~bus.deq))                      err_evt = 1'b1;
    if (|(bus.deq & empty))                               err_evt = 1'b1;
    if ((bus.deq & (bus.deq - vc_t'(1))) != '0)           err_evt = 1'b1;
    if (bus.flit_valid &&
        ((bus.flit.control.vc_id == '0) ||
         ((bus.flit.control.vc_id & (bus.flit.control.vc_id - vc_t'(1))) != '0)))
                                                          err_evt = 1'b1;
    err_d = err_q | err_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (err_evt) $error("nl_vc_in_buffer: protocol violation");
    end
  end

  assign buf_err = err_q;
`endif

endmodule

// File: tb/tb_nl_vc_in_buffer.sv
// Directed bench: depth-4 and depth-3 buffers share one stimulus, checked against a queue model.
module tb_nl_vc_in_buffer;
  import nl_vc_in_buffer_pkg::*;

  logic  clk;
  logic  rst;
  flit_t flit;
  logic  flit_valid;
  vc_t   deq;

  int n_checks = 0;
  int n_fail   = 0;

  nl_vc_in_buffer_if ifa ();
  nl_vc_in_buffer_if ifb ();

  assign ifa.flit       = flit;
  assign ifa.flit_valid = flit_valid;
  assign ifa.deq        = deq;
  assign ifb.flit       = flit;
  assign ifb.flit_valid = flit_valid;
  assign ifb.deq        = deq;

`ifdef NL_VC_BUF_CHECK_EN
  logic buf_err_a, buf_err_b;
  logic errs [2];
  assign errs[0] = buf_err_a;
  assign errs[1] = buf_err_b;
`endif

  nl_vc_in_buffer #(.buf_depth(4)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .bus    (ifa)
`ifdef NL_VC_BUF_CHECK_EN
    ,
    .buf_err(buf_err_a)
`endif
  );

  nl_vc_in_buffer #(.buf_depth(3)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .bus    (ifb)
`ifdef NL_VC_BUF_CHECK_EN
    ,
    .buf_err(buf_err_b)
`endif
  );

  vc_t                 hv [2];
  flit_t [num_vcs-1:0] hd [2];
  chan_cntrl_t         cc [2];
  assign hv[0] = ifa.vc_head_valid;
  assign hv[1] = ifb.vc_head_valid;
  assign hd[0] = ifa.vc_head;
  assign hd[1] = ifb.vc_head;
  assign cc[0] = ifa.channel_cntrl_out;
  assign cc[1] = ifb.channel_cntrl_out;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per-instance, per-VC queues of payloads; expected credit and sticky error.
  int unsigned depth_of [2] = '{4, 3};
  logic [15:0] mq [2][num_vcs][$];
  bit          exp_cv  [2];
  int          exp_cr  [2];
  bit          exp_err [2];
  int          cred_cnt [2][num_vcs];
  bit          started = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cc[i].credit_valid === 1'b1) cred_cnt[i][int'(cc[i].credit)]++;
      if (rst) begin
        for (int v = 0; v < int'(num_vcs); v++) mq[i][v].delete();
        exp_cv[i]  = 1'b0;
        exp_cr[i]  = 0;
        exp_err[i] = 1'b0;
      end else begin
        int wv;
        wv = -1;
        for (int v = 0; v < int'(num_vcs); v++) if (flit.control.vc_id[v]) wv = v;
        if (flit_valid && wv >= 0 && mq[i][wv].size() == depth_of[i] && !deq[wv])
          exp_err[i] = 1'b1;
        exp_cv[i] = 1'b0;
        for (int v = 0; v < int'(num_vcs); v++) begin
          if (deq[v]) begin
            if (mq[i][v].size() > 0) begin
              void'(mq[i][v].pop_front());
              exp_cv[i] = 1'b1;
              exp_cr[i] = v;
            end else begin
              exp_err[i] = 1'b1;
            end
          end
        end
        if (flit_valid && wv >= 0 && mq[i][wv].size() < depth_of[i])
          mq[i][wv].push_back(flit.data);
      end
    end
    if (rst) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        for (int v = 0; v < int'(num_vcs); v++) begin
          check($sformatf("head_valid[%0d][%0d]", i, v), 32'(hv[i][v]),
                32'(mq[i][v].size() > 0));
          if (mq[i][v].size() > 0)
            check($sformatf("head_data[%0d][%0d]", i, v), 32'(hd[i][v].data),
                  32'(mq[i][v][0]));
        end
        check($sformatf("credit_valid[%0d]", i), 32'(cc[i].credit_valid), 32'(exp_cv[i]));
        if (exp_cv[i])
          check($sformatf("credit[%0d]", i), 32'(cc[i].credit), 32'(exp_cr[i]));
`ifdef NL_VC_BUF_CHECK_EN
        check($sformatf("buf_err[%0d]", i), 32'(errs[i]), 32'(exp_err[i]));
`endif
      end
    end
  end

  task automatic cyc(input bit v, input int vc, input logic [15:0] d, input vc_t dq);
    flit_valid           = v;
    flit.control.vc_id   = vc_t'(1) << vc;
    flit.data            = d;
    deq                  = dq;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 16'h0, '0);
  endtask

  int base_a, base_b;

  initial begin
    rst = 1'b1;
    flit_valid = 1'b0;
    flit = '0;
    deq = '0;
    @(negedge clk);
    idle();
    rst = 1'b0;

    // Reset, idle
    repeat (5) idle();
    check("idle_head_valid", 32'(hv[0]), 32'h0);
    check("idle_credit", 32'(cc[0].credit_valid), 32'h0);

    // Fill and drain VC1
    cyc(1'b1, 1, 16'h000A, '0);
    check("first_write_valid", 32'(hv[0]), 32'h2);
    check("first_write_head", 32'(hd[0][1].data), 32'hA);
    cyc(1'b1, 1, 16'h000B, '0);
    cyc(1'b1, 1, 16'h000C, '0);
    cyc(1'b1, 1, 16'h000D, '0);
    check("depth3_head_kept", 32'(hd[1][1].data), 32'hA);
    cyc(1'b0, 0, 16'h0, 2'b10);
    check("drain1_credit_valid", 32'(cc[0].credit_valid), 32'h1);
    check("drain1_credit_vc", 32'(cc[0].credit), 32'h1);
    check("drain1_next_head", 32'(hd[0][1].data), 32'hB);
    repeat (3) cyc(1'b0, 0, 16'h0, 2'b10);
    idle();
    check("vc1_credits_d4", 32'(cred_cnt[0][1]), 32'd4);
    check("vc1_credits_d3", 32'(cred_cnt[1][1]), 32'd3);

    // Full VC0 then simultaneous write + dequeue
    for (int k = 0; k < 4; k++) cyc(1'b1, 0, 16'h0010 + 16'(k), '0);
    cyc(1'b1, 0, 16'h0014, 2'b01);
    check("full_wd_head", 32'(hd[0][0].data), 32'h11);
    check("full_wd_credit", 32'(cc[0].credit_valid), 32'h1);
    check("full_wd_credit_vc", 32'(cc[0].credit), 32'h0);
    repeat (3) cyc(1'b0, 0, 16'h0, 2'b01);
    check("full_wd_tail", 32'(hd[0][0].data), 32'h14);
    cyc(1'b0, 0, 16'h0, 2'b01);
    idle();
    check("vc0_credits_d4", 32'(cred_cnt[0][0]), 32'd5);

    // Wrap-around streaming on VC0
    base_a = cred_cnt[0][0];
    base_b = cred_cnt[1][0];
    cyc(1'b1, 0, 16'h0020, '0);
    for (int k = 1; k < 10; k++) cyc(1'b1, 0, 16'h0020 + 16'(k), 2'b01);
    check("wrap_last_head", 32'(hd[1][0].data), 32'h29);
    cyc(1'b0, 0, 16'h0, 2'b01);
    idle();
    check("wrap_credits_d3", 32'(cred_cnt[1][0] - base_b), 32'd10);
    check("wrap_credits_d4", 32'(cred_cnt[0][0] - base_a), 32'd10);

    // Illegal events
    cyc(1'b0, 0, 16'h0, 2'b01);
    check("empty_deq_no_credit", 32'(cc[0].credit_valid), 32'h0);
`ifdef NL_VC_BUF_CHECK_EN
    check("empty_deq_err", 32'(buf_err_a), 32'h1);
`endif
    for (int k = 0; k < 5; k++) cyc(1'b1, 1, 16'h0030 + 16'(k), '0);
    check("overflow_head", 32'(hd[0][1].data), 32'h30);
    repeat (3) cyc(1'b0, 0, 16'h0, 2'b10);
    check("overflow_last", 32'(hd[0][1].data), 32'h33);
    cyc(1'b0, 0, 16'h0, 2'b10);
    check("overflow_dropped", 32'(hv[0]), 32'h0);
`ifdef NL_VC_BUF_CHECK_EN
    check("err_sticky", 32'(buf_err_a), 32'h1);
`endif

    // Reset mid-operation
    cyc(1'b1, 1, 16'h0040, '0);
    cyc(1'b1, 1, 16'h0041, '0);
    cyc(1'b0, 0, 16'h0, 2'b10);
    check("pre_reset_credit", 32'(cc[0].credit_valid), 32'h1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("reset_credit_suppressed", 32'(cc[0].credit_valid), 32'h0);
    check("reset_heads_a", 32'(hv[0]), 32'h0);
    check("reset_heads_b", 32'(hv[1]), 32'h0);
`ifdef NL_VC_BUF_CHECK_EN
    check("reset_err_cleared", 32'(buf_err_a), 32'h0);
`endif
    cyc(1'b1, 0, 16'h0050, '0);
    check("post_reset_write", 32'(hd[0][0].data), 32'h50);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
